// File: rtl/fpu_class_pkg.sv
// Shared FCLASS definitions: class bit positions and the one-hot class type.
package fpu_class_pkg;

  localparam int NUM_CLASSES = 10;

  localparam int CLS_NINF  = 0;
  localparam int CLS_NNORM = 1;
  localparam int CLS_NSUB  = 2;
  localparam int CLS_NZERO = 3;
  localparam int CLS_PZERO = 4;
  localparam int CLS_PSUB  = 5;
  localparam int CLS_PNORM = 6;
  localparam int CLS_PINF  = 7;
  localparam int CLS_SNAN  = 8;
  localparam int CLS_QNAN  = 9;

  typedef logic [NUM_CLASSES-1:0] fclass_t;

endpackage

// File: rtl/fpu_class_lane.sv
// One classifier lane. The field decode and the one-hot encode are two
// independent combinational paths so the parent can place a register between them.
module fpu_class_lane
  import fpu_class_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] operand,
  output logic                 sign,
  output logic                 exp_ones,
  output logic                 exp_zero,
  output logic                 man_zero,
  output logic                 man_msb,
  input  logic                 s_sign,
  input  logic                 s_exp_ones,
  input  logic                 s_exp_zero,
  input  logic                 s_man_zero,
  input  logic                 s_man_msb,
  input  logic                 s_en,
  output fclass_t              cls
);

  logic [EXP_W-1:0] exp_field;
  logic [MAN_W-1:0] man_field;

  assign exp_field = operand[MAN_W +: EXP_W];
  assign man_field = operand[MAN_W-1:0];

  // Field decode: reduce the operand to the five flags the encoder needs.
  always_comb begin
    sign     = operand[EXP_W+MAN_W];
    exp_ones = &exp_field;
    exp_zero = ~|exp_field;
    man_zero = ~|man_field;
    man_msb  = man_field[MAN_W-1];
  end

  // One-hot encode from registered flags; a disabled lane yields no class.
  always_comb begin
    cls = '0;
    if (s_en) begin
      if (s_exp_ones) begin
        if (s_man_zero)     cls[s_sign ? CLS_NINF : CLS_PINF] = 1'b1;
        else if (s_man_msb) cls[CLS_QNAN] = 1'b1;
        else                cls[CLS_SNAN] = 1'b1;
      end else if (s_exp_zero) begin
        if (s_man_zero) cls[s_sign ? CLS_NZERO : CLS_PZERO] = 1'b1;
        else            cls[s_sign ? CLS_NSUB  : CLS_PSUB]  = 1'b1;
      end else begin
        cls[s_sign ? CLS_NNORM : CLS_PNORM] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_classifier_pipe.sv
// Two-stage multi-lane FCLASS pipeline with valid/ready flow control and
// running class statistics (sticky class OR, saturating NaN lane count).
module fpu_classifier_pipe
  import fpu_class_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0] in_data,
  input  logic [LANES-1:0]                 in_lane_en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES*NUM_CLASSES-1:0]     out_class,
  output logic [LANES-1:0]                 out_lane_en,
  input  logic                             clr_stats,
  output fclass_t                          sticky_class,
  output logic [CNT_W-1:0]                 nan_count
);

  localparam int FW    = 1 + EXP_W + MAN_W;
  localparam int SUM_W = $clog2(LANES + 1);
  localparam int ACC_W = CNT_W + SUM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                         s1_valid;
  logic                         s1_adv;
  logic                         s2_adv;
  logic                         out_hs;
  logic [LANES-1:0]             d_sign, d_exp_ones, d_exp_zero, d_man_zero, d_man_msb;
  logic [LANES-1:0]             s1_sign, s1_exp_ones, s1_exp_zero, s1_man_zero, s1_man_msb, s1_en;
  logic [LANES*NUM_CLASSES-1:0] cls_next;
  fclass_t                      deliver_or;
  logic [SUM_W-1:0]             nan_lanes;
  logic [ACC_W-1:0]             nan_sum;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      fpu_class_lane #(
        .EXP_W(EXP_W),
        .MAN_W(MAN_W)
      ) u_lane (
        .operand   (in_data[gi*FW +: FW]),
        .sign      (d_sign[gi]),
        .exp_ones  (d_exp_ones[gi]),
        .exp_zero  (d_exp_zero[gi]),
        .man_zero  (d_man_zero[gi]),
        .man_msb   (d_man_msb[gi]),
        .s_sign    (s1_sign[gi]),
        .s_exp_ones(s1_exp_ones[gi]),
        .s_exp_zero(s1_exp_zero[gi]),
        .s_man_zero(s1_man_zero[gi]),
        .s_man_msb (s1_man_msb[gi]),
        .s_en      (s1_en[gi]),
        .cls       (cls_next[gi*NUM_CLASSES +: NUM_CLASSES])
      );
    end
  endgenerate

  // A stage advances when it is empty or its contents leave this cycle.
  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign out_hs   = out_valid & out_ready;

  // Stage 1: capture decoded flags and lane enables of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_sign     <= '0;
      s1_exp_ones <= '0;
      s1_exp_zero <= '0;
      s1_man_zero <= '0;
      s1_man_msb  <= '0;
      s1_en       <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign     <= d_sign;
        s1_exp_ones <= d_exp_ones;
        s1_exp_zero <= d_exp_zero;
        s1_man_zero <= d_man_zero;
        s1_man_msb  <= d_man_msb;
        s1_en       <= in_lane_en;
      end
    end
  end

  // Stage 2: register the one-hot classes; held stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_class   <= '0;
      out_lane_en <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_class   <= cls_next;
        out_lane_en <= s1_en;
      end
    end
  end

  // Gather the delivered beat's class OR and its number of NaN lanes.
  always_comb begin
    deliver_or = '0;
    nan_lanes  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (out_lane_en[i]) begin
        deliver_or = deliver_or | out_class[i*NUM_CLASSES +: NUM_CLASSES];
        nan_lanes  = nan_lanes + SUM_W'(out_class[i*NUM_CLASSES + CLS_SNAN]
                                      | out_class[i*NUM_CLASSES + CLS_QNAN]);
      end
    end
    nan_sum = ACC_W'(nan_count) + ACC_W'(nan_lanes);
  end

  // Statistics: clear wins over a coincident handshake; count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_class <= '0;
      nan_count    <= '0;
    end else if (clr_stats) begin
      sticky_class <= '0;
      nan_count    <= '0;
    end else if (out_hs) begin
      sticky_class <= sticky_class | deliver_or;
      nan_count    <= (nan_sum > ACC_W'(CNT_MAX)) ? CNT_MAX : nan_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_fpu_classifier_pipe.sv
// Randomized and directed bench for fpu_classifier_pipe with a queue-based reference model.
module tb_fpu_classifier_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] in_data = '0;
  logic [1:0]  in_lane_en = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [19:0] out_class;
  logic [1:0]  out_lane_en;
  logic        clr_stats = 1'b0;
  logic [9:0]  sticky_class;
  logic [3:0]  nan_count;

  logic        h_in_valid = 1'b0, h_in_ready, h_out_valid;
  logic [31:0] h_in_data = '0;
  logic [19:0] h_out_class;
  logic [1:0]  h_out_lane_en;
  logic [9:0]  h_sticky;
  logic [15:0] h_nan_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fpu_classifier_pipe #(.EXP_W(8), .MAN_W(23), .LANES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_lane_en(in_lane_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_lane_en(out_lane_en),
    .clr_stats(clr_stats), .sticky_class(sticky_class), .nan_count(nan_count)
  );

  fpu_classifier_pipe #(.EXP_W(5), .MAN_W(10), .LANES(2), .CNT_W(16)) dut_half (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_data(h_in_data), .in_lane_en(2'b11), .out_valid(h_out_valid),
    .out_ready(1'b1), .out_class(h_out_class), .out_lane_en(h_out_lane_en),
    .clr_stats(1'b0), .sticky_class(h_sticky), .nan_count(h_nan_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // IEEE class from field values: index 0..9 as listed for FCLASS.
  function automatic logic [9:0] fclass(input bit sign, input int unsigned e,
                                        input longint unsigned m, input int ew, input int mw);
    int unsigned emax;
    int idx;
    logic [9:0] r;
    emax = (32'd1 << ew) - 1;
    if (e == emax)  idx = (m == 0) ? (sign ? 0 : 7) : (((m >> (mw - 1)) & 1) != 0 ? 9 : 8);
    else if (e == 0) idx = (m == 0) ? (sign ? 3 : 4) : (sign ? 2 : 5);
    else             idx = sign ? 1 : 6;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [9:0] cls_sp(input logic [31:0] w);
    return fclass(w[31], w[30:23], w[22:0], 8, 23);
  endfunction

  function automatic logic [19:0] model_beat(input logic [63:0] d, input logic [1:0] en);
    logic [19:0] r;
    r[9:0]   = en[0] ? cls_sp(d[31:0])  : 10'h000;
    r[19:10] = en[1] ? cls_sp(d[63:32]) : 10'h000;
    return r;
  endfunction

  function automatic logic [31:0] rand_sp();
    logic [7:0]  e;
    logic [22:0] m;
    case ($urandom_range(0, 3))
      0: e = 8'h00;
      1: e = 8'hFF;
      default: e = 8'($urandom_range(1, 254));
    endcase
    case ($urandom_range(0, 3))
      0: m = '0;
      1: m = 23'h400000 | 23'($urandom());
      2: m = 23'($urandom_range(1, 3));
      default: m = 23'($urandom());
    endcase
    return {1'($urandom()), e, m};
  endfunction

  typedef struct {
    logic [19:0] cls;
    logic [1:0]  en;
    int          cyc;
  } beat_t;

  beat_t      q[$];
  logic [9:0] m_sticky = '0;
  int         m_nan = 0;
  int         cyc = 0;
  int         pops = 0;

  // Reference model and per-cycle compare, sampled mid-cycle with inputs stable.
  always @(negedge clk) begin
    if (rst_n) begin
      bit exp_ov;
      beat_t b;
      cyc++;
      chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_class", 32'(out_class), 32'(q[0].cls));
        chk("out_lane_en", 32'(out_lane_en), 32'(q[0].en));
      end
      chk("sticky_class", 32'(sticky_class), 32'(m_sticky));
      chk("nan_count", 32'(nan_count), 32'(m_nan));
      if (exp_ov && out_ready) begin
        b = q.pop_front();
        pops++;
        if (!clr_stats) begin
          for (int l = 0; l < 2; l++) begin
            m_sticky |= b.cls[l*10 +: 10];
            if (b.cls[l*10 + 8] || b.cls[l*10 + 9]) m_nan++;
          end
          if (m_nan > 15) m_nan = 15;
        end
      end
      if (clr_stats) begin
        m_sticky = '0;
        m_nan = 0;
      end
      if (in_valid && in_ready) begin
        b.cls = model_beat(in_data, in_lane_en);
        b.en  = in_lane_en;
        b.cyc = cyc;
        q.push_back(b);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [1:0] en,
                       input logic ordy, input logic clr);
    in_valid = v; in_data = d; in_lane_en = en; out_ready = ordy; clr_stats = clr;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
    while ((q.size() != 0 || out_valid) && n < 40) begin
      tick();
      n++;
    end
    tick();
    chk({name, "_drain_timeout"}, 32'(n >= 40), 32'd0);
  endtask

  logic [31:0] sp_ops[6] = '{32'hFF800000, 32'h7FC00000, 32'h7F800001,
                             32'h00000001, 32'h80000000, 32'h3F800000};
  logic [19:0] sp_exp[3] = '{{10'h200, 10'h001}, {10'h020, 10'h100}, {10'h040, 10'h008}};

  initial begin
    logic [63:0] bp_data[8];
    int idx, n, p0;

    // Pin the reference model against hand-computed codes.
    chk("model_ninf",  32'(cls_sp(32'hFF800000)), 32'h001);
    chk("model_qnan",  32'(cls_sp(32'h7FC00000)), 32'h200);
    chk("model_snan",  32'(cls_sp(32'h7F800001)), 32'h100);
    chk("model_psub",  32'(cls_sp(32'h00000001)), 32'h020);
    chk("model_nzero", 32'(cls_sp(32'h80000000)), 32'h008);
    chk("model_pnorm", 32'(cls_sp(32'h3F800000)), 32'h040);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_lane_en", 32'(out_lane_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-precision sweep: literal expectations two cycles after acceptance.
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k >= 2) chk("sp_sweep", 32'(out_class), 32'(sp_exp[k-2]));
      if (k < 3) drive(1'b1, {sp_ops[2*k+1], sp_ops[2*k]}, 2'b11, 1'b1, 1'b0);
      else       drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
    end
    wait_drain("sp");

    // Half precision on the second instance.
    h_in_valid = 1'b1; h_in_data = {16'hFE00, 16'h7C00};
    tick(); h_in_data = {16'h0000, 16'h8001};
    tick(); h_in_valid = 1'b0;
    chk("hp_valid", 32'(h_out_valid), 32'd1);
    chk("hp_beat0", 32'(h_out_class), 32'({10'h200, 10'h080}));
    tick();
    chk("hp_beat1", 32'(h_out_class), 32'({10'h010, 10'h004}));
    tick();
    chk("hp_nan_count", 32'(h_nan_count), 32'd1);
    chk("hp_sticky", 32'(h_sticky), 32'h294);

    // Backpressure: 8 beats while out_ready cycles 1,0,0,1.
    for (int i = 0; i < 8; i++) bp_data[i] = {rand_sp(), rand_sp()};
    p0 = pops; idx = 0; n = 0;
    while (idx < 8 && n < 100) begin
      drive(1'b1, bp_data[idx], 2'b11, (n % 4 == 0) || (n % 4 == 3), 1'b0);
      @(negedge clk);
      if (in_ready) idx++;
      tick();
      n++;
    end
    chk("bp_timeout", 32'(n >= 100), 32'd0);
    wait_drain("bp");
    chk("bp_delivered", 32'(pops - p0), 32'd8);

    // Lane enable: only lane 0 counts.
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1); tick();
    drive(1'b1, {32'h7FC00000, 32'h7FC00000}, 2'b01, 1'b1, 1'b0); tick();
    wait_drain("lane_en");
    chk("lane_en_nan", 32'(nan_count), 32'd1);
    chk("lane_en_sticky", 32'(sticky_class), 32'h200);

    // Saturation: 20 NaN lanes into a 4-bit counter.
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1); tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, {32'h7FC00000, 32'h7F800001}, 2'b11, 1'b1, 1'b0); tick();
    end
    wait_drain("sat");
    chk("sat_nan", 32'(nan_count), 32'd15);
    chk("sat_sticky", 32'(sticky_class), 32'h300);

    // Clear coincident with a NaN handshake wins.
    drive(1'b1, {32'h7FC00000, 32'h7FC00000}, 2'b11, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 2'b00, 1'b1, 1'b0); tick();
    chk("clr_hs_valid", 32'(out_valid), 32'd1);
    drive(1'b0, '0, 2'b00, 1'b1, 1'b1); tick();
    drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
    chk("clr_hs_nan", 32'(nan_count), 32'd0);
    chk("clr_hs_sticky", 32'(sticky_class), 32'd0);
    wait_drain("clr");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {rand_sp(), rand_sp()}, 2'($urandom()),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
      tick();
    end
    wait_drain("rand");

    // Reset with both stages full, then one clean beat.
    drive(1'b1, {32'h7FC00000, 32'h7F800000}, 2'b11, 1'b1, 1'b0); tick();
    drive(1'b1, {32'h7FC00000, 32'h7FC00000}, 2'b11, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 2'b00, 1'b0, 1'b0); tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_nan", 32'(nan_count), 32'd0);
    chk("arst_sticky", 32'(sticky_class), 32'd0);
    q.delete(); m_sticky = '0; m_nan = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(1'b1, {32'h80000000, 32'h3F800000}, 2'b11, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 2'b00, 1'b1, 1'b0); tick();
    chk("post_rst_beat", 32'(out_class), 32'({10'h008, 10'h040}));
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
